load_align_unit: RTL and testbench

- Memory-stage load path: accepts a load request from the pipeline, issues a word-aligned read to data memory, waits for a variable-latency response, then extracts and sign- or zero-extends the addressed byte, halfword or word.
- Holds the 32-bit result until the writeback side accepts it.
- Stalls the pipeline while a load is outstanding.
- Sits between the MEM-stage address/control registers and the MEM/WB pipeline register.

---
 rtl/load_align_unit_pkg.sv | 32 +++
 rtl/load_align_unit_if.sv | 30 +++
 rtl/load_align_unit_extract.sv | 37 +++
 rtl/load_align_unit.sv | 116 +++++++++++
 tb/tb_load_align_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/load_align_unit_pkg.sv
// Shared types and constants for the load path: size encodings, FSM states,
// default memory timeout and the alignment legality rule.
package load_align_unit_pkg;

  localparam int WORD_W                 = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } load_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Bytes may sit anywhere; halfwords need an even address; words need
  // a word-aligned address; the reserved size is never legal.
  function automatic logic load_is_legal(input load_size_e size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lane[0];
      SZ_WORD: return (lane == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Pipeline-side request/result handshake plus the data-memory read port.
// slave is the load unit's view, master is the pipeline/memory view.
interface load_align_unit_if #(parameter int DATA_W = 32);

  logic              LoadReq;
  logic [1:0]        LoadSize;
  logic              LoadUnsigned;
  logic [DATA_W-1:0] Address;
  logic              MemReadEn;
  logic [DATA_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemRdata;
  logic              MemValid;
  logic [DATA_W-1:0] DataOut;
  logic              DataValid;
  logic              DataAccept;
  logic              Stall;
  logic              AlignErr;
  logic              TimeoutErr;

  modport slave (
    input  LoadReq, LoadSize, LoadUnsigned, Address, MemRdata, MemValid, DataAccept,
    output MemReadEn, MemAddr, DataOut, DataValid, Stall, AlignErr, TimeoutErr
  );

  modport master (
    output LoadReq, LoadSize, LoadUnsigned, Address, MemRdata, MemValid, DataAccept,
    input  MemReadEn, MemAddr, DataOut, DataValid, Stall, AlignErr, TimeoutErr
  );

endinterface

// File: rtl/load_align_unit_extract.sv
// Pure combinational lane select and sign/zero extension of a memory word.
// Little-endian lanes; kept standalone so the store-path checker can reuse it.
module load_extract
  import load_align_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  load_size_e  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane, then extend it according to size and signedness.
  always_comb begin
    byte_v = word[7:0];
    case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase

    half_v = lane[1] ? word[31:16] : word[15:0];

    result = '0;
    case (size)
      SZ_BYTE: result = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      SZ_HALF: result = {{16{~is_unsigned & half_v[15]}}, half_v};
      SZ_WORD: result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// MEM-stage load unit: checks alignment, issues a word-aligned read, waits
// (bounded) for the memory, then holds the extended result for writeback.
//
//   state  | meaning
//   S_IDLE | no load outstanding, LoadReq sampled
//   S_WAIT | read strobe up, waiting for MemValid or timeout
//   S_DONE | result/error held until DataAccept
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int DATA_W         = WORD_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic             Clk,
  input logic             Reset,
  load_align_unit_if.slave bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e            state;
  logic [7:0]        cnt;
  load_size_e        size_q;
  logic [1:0]        lane_q;
  logic              uns_q;
  logic [DATA_W-1:0] extracted;
  logic              req_legal;

  assign req_legal = load_is_legal(load_size_e'(bus.LoadSize), bus.Address[1:0]);
  assign bus.Stall = (state != S_IDLE);

  // Extraction works on the captured request, so it stays correct while
  // the pipeline moves Address on during the wait.
  load_extract u_extract (
    .word        (bus.MemRdata),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (extracted)
  );

  // Load sequencing FSM with registered memory strobe, result and flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      size_q         <= SZ_BYTE;
      lane_q         <= '0;
      uns_q          <= 1'b0;
      bus.MemReadEn  <= 1'b0;
      bus.MemAddr    <= '0;
      bus.DataOut    <= '0;
      bus.DataValid  <= 1'b0;
      bus.AlignErr   <= 1'b0;
      bus.TimeoutErr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.LoadReq) begin
            size_q <= load_size_e'(bus.LoadSize);
            lane_q <= bus.Address[1:0];
            uns_q  <= bus.LoadUnsigned;
            if (req_legal) begin
              state         <= S_WAIT;
              cnt           <= '0;
              bus.MemReadEn <= 1'b1;
              bus.MemAddr   <= {bus.Address[DATA_W-1:2], 2'b00};
            end else begin
              // Illegal requests never touch memory.
              state         <= S_DONE;
              bus.DataOut   <= '0;
              bus.DataValid <= 1'b1;
              bus.AlignErr  <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (bus.MemValid) begin
            // Data beats the timeout even on the final count.
            state          <= S_DONE;
            bus.MemReadEn  <= 1'b0;
            bus.DataOut    <= extracted;
            bus.DataValid  <= 1'b1;
            bus.TimeoutErr <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state          <= S_DONE;
            bus.MemReadEn  <= 1'b0;
            bus.DataOut    <= '0;
            bus.DataValid  <= 1'b1;
            bus.TimeoutErr <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_DONE: begin
          // A LoadReq alongside DataAccept is left for the next IDLE cycle.
          if (bus.DataAccept) begin
            state          <= S_IDLE;
            bus.DataValid  <= 1'b0;
            bus.AlignErr   <= 1'b0;
            bus.TimeoutErr <= 1'b0;
          end
        end

        default: begin
          state         <= S_IDLE;
          bus.MemReadEn <= 1'b0;
          bus.DataValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: extraction, alignment errors, timeout,
// result hold, accept/request overlap and reset during a pending load.
module tb_load_align_unit;
  import load_align_unit_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  load_align_unit_if bus ();

  load_align_unit #(.DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
    int          k;
  } vec_t;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.LoadReq = 1'b0; bus.LoadSize = 2'b00; bus.LoadUnsigned = 1'b0;
    bus.Address = '0; bus.MemRdata = 32'hDEADBEEF; bus.MemValid = 1'b0;
    bus.DataAccept = 1'b0;
  endtask

  task automatic issue(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
    bus.LoadReq = 1'b1; bus.LoadSize = sz; bus.LoadUnsigned = uns; bus.Address = addr;
    step();
    bus.LoadReq = 1'b0;
  endtask

  task automatic accept();
    bus.DataAccept = 1'b1;
    step();
    bus.DataAccept = 1'b0;
  endtask

  // Issue a load, answer in WAIT cycle k (cycle 1 = first MemReadEn cycle,
  // 0 = never), wait a bounded time for DataValid and report what was seen.
  task automatic run_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                          input logic [31:0] rdata, input int k,
                          output logic mre, output logic [31:0] maddr,
                          output logic [31:0] dout, output logic valid,
                          output logic aerr, output logic terr, output int lat);
    int cyc;
    cyc = 1; valid = 1'b0; lat = -1;
    issue(sz, uns, addr);
    mre = bus.MemReadEn; maddr = bus.MemAddr;
    while (cyc < 40) begin
      if (cyc == k) begin bus.MemValid = 1'b1; bus.MemRdata = rdata; end
      step();
      bus.MemValid = 1'b0; bus.MemRdata = 32'hDEADBEEF;
      cyc++;
      if (bus.DataValid === 1'b1) begin valid = 1'b1; lat = cyc - 1; break; end
    end
    dout = bus.DataOut; aerr = bus.AlignErr; terr = bus.TimeoutErr;
  endtask

  task automatic test_reset();
    Reset = 1'b1; idle_inputs();
    step(); step();
    n_cmp++; if (bus.MemReadEn !== 1'b0) begin n_err++; $display("FAIL rst_mre got %b exp 0", bus.MemReadEn); end
    n_cmp++; if (bus.MemAddr !== 32'h0) begin n_err++; $display("FAIL rst_maddr got %h exp 0", bus.MemAddr); end
    n_cmp++; if (bus.DataOut !== 32'h0) begin n_err++; $display("FAIL rst_dout got %h exp 0", bus.DataOut); end
    n_cmp++; if (bus.DataValid !== 1'b0) begin n_err++; $display("FAIL rst_dv got %b exp 0", bus.DataValid); end
    n_cmp++; if (bus.AlignErr !== 1'b0 || bus.TimeoutErr !== 1'b0) begin n_err++; $display("FAIL rst_flags got %b%b exp 00", bus.AlignErr, bus.TimeoutErr); end
    n_cmp++; if (bus.Stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", bus.Stall); end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_extract();
    vec_t v[11];
    logic mre, valid, aerr, terr;
    logic [31:0] maddr, dout;
    int lat;
    v[0]  = '{SZ_BYTE, 1'b0, 32'h1003, 32'h80FF1234, 32'hFFFFFF80, 4};
    v[1]  = '{SZ_BYTE, 1'b1, 32'h1003, 32'h80FF1234, 32'h00000080, 1};
    v[2]  = '{SZ_HALF, 1'b1, 32'h1002, 32'h80FF1234, 32'h000080FF, 2};
    v[3]  = '{SZ_HALF, 1'b0, 32'h1000, 32'h80FF1234, 32'h00001234, 3};
    v[4]  = '{SZ_HALF, 1'b0, 32'h1002, 32'h80FF1234, 32'hFFFF80FF, 1};
    v[5]  = '{SZ_BYTE, 1'b0, 32'h1001, 32'h80FF1234, 32'h00000012, 2};
    v[6]  = '{SZ_BYTE, 1'b0, 32'h1002, 32'h80FF1234, 32'hFFFFFFFF, 1};
    v[7]  = '{SZ_WORD, 1'b1, 32'h1000, 32'h80FF1234, 32'h80FF1234, 5};
    v[8]  = '{SZ_BYTE, 1'b1, 32'h1000, 32'h7F0000F5, 32'h000000F5, 1};
    v[9]  = '{SZ_BYTE, 1'b0, 32'hABCD1000, 32'h7F0000F5, 32'hFFFFFFF5, 2};
    v[10] = '{SZ_HALF, 1'b0, 32'h1000, 32'h00007FFF, 32'h00007FFF, 1};
    for (int i = 0; i < 11; i++) begin
      run_load(v[i].sz, v[i].uns, v[i].addr, v[i].rdata, v[i].k, mre, maddr, dout, valid, aerr, terr, lat);
      n_cmp++; if (mre !== 1'b1) begin n_err++; $display("FAIL ext%0d_mre got %b exp 1", i, mre); end
      n_cmp++; if (maddr !== {v[i].addr[31:2], 2'b00}) begin n_err++; $display("FAIL ext%0d_maddr got %h exp %h", i, maddr, {v[i].addr[31:2], 2'b00}); end
      n_cmp++; if (valid !== 1'b1 || lat !== v[i].k) begin n_err++; $display("FAIL ext%0d_latency got valid=%b lat=%0d exp valid=1 lat=%0d", i, valid, lat, v[i].k); end
      n_cmp++; if (dout !== v[i].exp) begin n_err++; $display("FAIL ext%0d_dout got %h exp %h", i, dout, v[i].exp); end
      n_cmp++; if (aerr !== 1'b0 || terr !== 1'b0) begin n_err++; $display("FAIL ext%0d_flags got %b%b exp 00", i, aerr, terr); end
      accept();
      n_cmp++; if (bus.DataValid !== 1'b0 || bus.Stall !== 1'b0) begin n_err++; $display("FAIL ext%0d_accept got dv=%b stall=%b exp 0 0", i, bus.DataValid, bus.Stall); end
    end
  endtask

  task automatic test_align_err();
    logic [1:0]  sz[4];
    logic [31:0] ad[4];
    sz[0] = SZ_WORD; ad[0] = 32'h1001;
    sz[1] = SZ_WORD; ad[1] = 32'h1002;
    sz[2] = SZ_HALF; ad[2] = 32'h1003;
    sz[3] = SZ_RSVD; ad[3] = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      issue(sz[i], 1'b0, ad[i]);
      n_cmp++; if (bus.MemReadEn !== 1'b0) begin n_err++; $display("FAIL aerr%0d_mre got %b exp 0", i, bus.MemReadEn); end
      n_cmp++; if (bus.DataValid !== 1'b1 || bus.AlignErr !== 1'b1) begin n_err++; $display("FAIL aerr%0d_flag got dv=%b aerr=%b exp 1 1", i, bus.DataValid, bus.AlignErr); end
      n_cmp++; if (bus.DataOut !== 32'h0 || bus.TimeoutErr !== 1'b0) begin n_err++; $display("FAIL aerr%0d_dout got %h terr=%b exp 0 0", i, bus.DataOut, bus.TimeoutErr); end
      n_cmp++; if (bus.Stall !== 1'b1) begin n_err++; $display("FAIL aerr%0d_stall got %b exp 1", i, bus.Stall); end
      accept();
      n_cmp++; if (bus.DataValid !== 1'b0 || bus.AlignErr !== 1'b0) begin n_err++; $display("FAIL aerr%0d_clear got dv=%b aerr=%b exp 0 0", i, bus.DataValid, bus.AlignErr); end
    end
  endtask

  task automatic test_timeout();
    logic mre, valid, aerr, terr;
    logic [31:0] maddr, dout;
    int lat;
    run_load(SZ_WORD, 1'b0, 32'h2000, 32'h0, 0, mre, maddr, dout, valid, aerr, terr, lat);
    n_cmp++; if (valid !== 1'b1 || lat !== 16) begin n_err++; $display("FAIL tmo_latency got valid=%b lat=%0d exp valid=1 lat=16", valid, lat); end
    n_cmp++; if (terr !== 1'b1 || aerr !== 1'b0) begin n_err++; $display("FAIL tmo_flags got terr=%b aerr=%b exp 1 0", terr, aerr); end
    n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL tmo_dout got %h exp 0", dout); end
    accept();
    n_cmp++; if (bus.TimeoutErr !== 1'b0 || bus.Stall !== 1'b0) begin n_err++; $display("FAIL tmo_clear got terr=%b stall=%b exp 0 0", bus.TimeoutErr, bus.Stall); end
    run_load(SZ_WORD, 1'b0, 32'h2000, 32'h12345678, 16, mre, maddr, dout, valid, aerr, terr, lat);
    n_cmp++; if (valid !== 1'b1 || lat !== 16) begin n_err++; $display("FAIL last_latency got valid=%b lat=%0d exp valid=1 lat=16", valid, lat); end
    n_cmp++; if (terr !== 1'b0) begin n_err++; $display("FAIL last_terr got %b exp 0", terr); end
    n_cmp++; if (dout !== 32'h12345678) begin n_err++; $display("FAIL last_dout got %h exp 12345678", dout); end
    accept();
  endtask

  task automatic test_hold();
    logic mre, valid, aerr, terr;
    logic [31:0] maddr, dout;
    int lat;
    run_load(SZ_BYTE, 1'b1, 32'h1000, 32'h80FF1234, 1, mre, maddr, dout, valid, aerr, terr, lat);
    n_cmp++; if (dout !== 32'h00000034 || lat !== 1) begin n_err++; $display("FAIL hold_first got %h lat=%0d exp 00000034 lat=1", dout, lat); end
    for (int i = 0; i < 5; i++) begin
      bus.MemValid = (i % 2 == 0); bus.MemRdata = 32'hFFFFFFFF;
      step();
      n_cmp++; if (bus.DataOut !== 32'h00000034 || bus.DataValid !== 1'b1 || bus.Stall !== 1'b1) begin n_err++; $display("FAIL hold%0d got dout=%h dv=%b stall=%b exp 00000034 1 1", i, bus.DataOut, bus.DataValid, bus.Stall); end
    end
    bus.MemValid = 1'b0;
    accept();
    for (int i = 0; i < 3; i++) begin
      bus.MemValid = 1'b1; bus.MemRdata = 32'h55AA55AA;
      step();
      n_cmp++; if (bus.DataValid !== 1'b0 || bus.Stall !== 1'b0 || bus.MemReadEn !== 1'b0) begin n_err++; $display("FAIL idle_stray%0d got dv=%b stall=%b mre=%b exp 0 0 0", i, bus.DataValid, bus.Stall, bus.MemReadEn); end
    end
    bus.MemValid = 1'b0;
  endtask

  task automatic test_accept_with_req();
    logic mre, valid, aerr, terr;
    logic [31:0] maddr, dout;
    int lat;
    run_load(SZ_HALF, 1'b0, 32'h1002, 32'h80FF1234, 2, mre, maddr, dout, valid, aerr, terr, lat);
    n_cmp++; if (dout !== 32'hFFFF80FF) begin n_err++; $display("FAIL ovl_first got %h exp FFFF80FF", dout); end
    bus.DataAccept = 1'b1;
    bus.LoadReq = 1'b1; bus.LoadSize = SZ_WORD; bus.LoadUnsigned = 1'b0; bus.Address = 32'h3000;
    step();
    bus.DataAccept = 1'b0;
    n_cmp++; if (bus.Stall !== 1'b0 || bus.MemReadEn !== 1'b0 || bus.DataValid !== 1'b0) begin n_err++; $display("FAIL ovl_not_taken got stall=%b mre=%b dv=%b exp 0 0 0", bus.Stall, bus.MemReadEn, bus.DataValid); end
    step();
    bus.LoadReq = 1'b0;
    n_cmp++; if (bus.MemReadEn !== 1'b1 || bus.MemAddr !== 32'h3000) begin n_err++; $display("FAIL ovl_taken got mre=%b maddr=%h exp 1 00003000", bus.MemReadEn, bus.MemAddr); end
    bus.MemValid = 1'b1; bus.MemRdata = 32'hCAFEF00D;
    step();
    bus.MemValid = 1'b0;
    n_cmp++; if (bus.DataValid !== 1'b1 || bus.DataOut !== 32'hCAFEF00D) begin n_err++; $display("FAIL ovl_result got dv=%b dout=%h exp 1 CAFEF00D", bus.DataValid, bus.DataOut); end
    accept();
  endtask

  task automatic test_reset_midflight();
    issue(SZ_WORD, 1'b0, 32'h2000);
    n_cmp++; if (bus.MemReadEn !== 1'b1) begin n_err++; $display("FAIL mid_mre got %b exp 1", bus.MemReadEn); end
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    bus.MemValid = 1'b1; bus.MemRdata = 32'h11111111;
    n_cmp++; if (bus.Stall !== 1'b0 || bus.MemReadEn !== 1'b0 || bus.MemAddr !== 32'h0) begin n_err++; $display("FAIL mid_rst got stall=%b mre=%b maddr=%h exp 0 0 0", bus.Stall, bus.MemReadEn, bus.MemAddr); end
    step();
    bus.MemValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (bus.DataValid !== 1'b0 || bus.DataOut !== 32'h0 || bus.Stall !== 1'b0 || bus.AlignErr !== 1'b0 || bus.TimeoutErr !== 1'b0) begin n_err++; $display("FAIL mid_after%0d got dv=%b dout=%h stall=%b flags=%b%b exp 0 0 0 00", i, bus.DataValid, bus.DataOut, bus.Stall, bus.AlignErr, bus.TimeoutErr); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_extract();
    test_align_err();
    test_timeout();
    test_hold();
    test_accept_with_req();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
